imem_loader: RTL

Program loader that writes the instruction memory that the fetch stage reads. It accepts a little-endian byte stream over a valid/ready handshake. The stream is a 4-byte word-count header followed by the program words. The block packs the bytes into 32-bit words, writes them through the instruction memory's write port, and holds the core in reset (`cpu_run` low) until the whole program is stored. It sits between the external download interface and `inst_mem`, and its `cpu_run` output gates the PC register.

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader
// -----------
// Downloads a program into instruction memory from a little-endian byte
// stream, then releases the core. The stream is a 4-byte word count N
// followed by N 32-bit words. Each word is written through the memory
// write port in a single-cycle WRITE slot. cpu_run stays low until the
// last word is stored.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse: begin a load (IDLE) or reload (DONE/ERR)
//   in_valid   byte-stream valid
//   in_data    byte-stream data (8 bits)
//   in_ready   loader accepts a byte this cycle (HDR, LOAD)
//   mem_we     instruction memory write enable, one pulse per word
//   mem_addr   word-aligned byte address of the word being written
//   mem_wdata  assembled instruction word
//   busy       load in progress (HDR, LOAD, WRITE)
//   cpu_run    program fully stored; core released (DONE)
//   err        header word count exceeds memory capacity (ERR)
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        cpu_run,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        WRITE,
        DONE,
        ERR
    } state_t;

    // Largest legal word count. Kept 33 bits wide so that the comparison
    // against a 32-bit header never overflows.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    state_t              state_reg;
    state_t              state_next;
    logic [1:0]          bcnt_reg;
    // One bit wider than the address so that N == 2^ADDR_WIDTH can be
    // reached without the index wrapping before the final compare.
    logic [ADDR_WIDTH:0] widx_reg;
    logic [31:0]         count_reg;
    logic [31:0]         addr_reg;
    logic [31:0]         wdata_reg;

    logic                accept;
    logic                last_byte;
    logic                last_word;
    logic [31:0]         assembled;

    assign accept    = in_valid & in_ready;
    assign last_byte = accept & (bcnt_reg == 2'd3);
    assign last_word = (32'(widx_reg) == (count_reg - 32'd1));

    // Byte lanes 0..2 are held in registers. Lane 3 is the byte that is
    // on the bus when the group completes, so it is taken straight from
    // in_data. The same lanes serve both the header and the program words.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane <= 8'h00;
            end else if (accept && (bcnt_reg == 2'(gi))) begin
                lane <= in_data;
            end
        end
    end

    assign assembled = {in_data, g_lane[2].lane, g_lane[1].lane, g_lane[0].lane};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (last_byte) begin
                    if (assembled == 32'd0) begin
                        state_next = DONE;
                    end else if ({1'b0, assembled} > CAPACITY) begin
                        state_next = ERR;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? DONE : LOAD;
            end
            DONE, ERR: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters and the write-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_reg  <= 2'd0;
            widx_reg  <= '0;
            count_reg <= 32'd0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
        end else begin
            // Outside a load the counters are kept cleared. As a result,
            // every entry into HDR starts from byte 0 and word 0.
            if ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR)) begin
                bcnt_reg <= 2'd0;
                widx_reg <= '0;
            end else begin
                if (accept) begin
                    bcnt_reg <= bcnt_reg + 2'd1;
                end
                if (state_reg == WRITE) begin
                    widx_reg <= widx_reg + 1'b1;
                end
            end

            if ((state_reg == HDR) && last_byte) begin
                count_reg <= assembled;
            end

            // Address and data are captured as the word completes.
            // They are then stable for the whole WRITE cycle, and they
            // hold their values afterwards.
            if ((state_reg == LOAD) && last_byte) begin
                addr_reg  <= 32'({widx_reg, 2'b00});
                wdata_reg <= assembled;
            end
        end
    end

    // Control outputs depend only on the registered state.
    assign in_ready  = (state_reg == HDR) || (state_reg == LOAD);
    assign busy      = (state_reg == HDR) || (state_reg == LOAD) || (state_reg == WRITE);
    assign mem_we    = (state_reg == WRITE);
    assign cpu_run   = (state_reg == DONE);
    assign err       = (state_reg == ERR);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule
